// File: rtl/multi_dataflow_stream_monitor_pkg.sv
// Shared types and defaults for the multi-channel stream monitor.
// The optional watchdog is enabled by MULTI_DATAFLOW_MONITOR_TIMEOUT_EN (see the top module).
package multi_dataflow_package;

    localparam int CNT_W_DEFAULT = 16;
    localparam int N_OUT_MAX     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } monitor_state_t;

    typedef struct packed {
        logic                     start;
        logic                     clear;
        logic [CNT_W_DEFAULT-1:0] target;
    } ctrl_monitor_t;

    // Status bundle sized for the largest supported configuration.
    typedef struct packed {
        logic                                    ready;
        logic                                    busy;
        logic                                    done;
        logic                                    overrun;
        logic                                    timeout;
        logic [N_OUT_MAX-1:0][CNT_W_DEFAULT-1:0] cnt;
    } flags_monitor_t;

endpackage

// File: rtl/multi_dataflow_stream_monitor_counter.sv
// One saturating per-channel handshake counter with target compare.
// Counts only while enabled and stops at the target; extra handshakes are reported as overrun.
module multi_dataflow_stream_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_zero_i,
    input  logic             count_en_i,
    input  logic             watch_en_i,
    input  logic             hs_i,
    input  logic [CNT_W-1:0] target_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             eq_target_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign eq_target_o = (cnt_q == target_i);
    assign overrun_o   = watch_en_i & hs_i & eq_target_o;
    assign cnt_o       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || load_zero_i) begin
            cnt_d = '0;
        end else if (count_en_i && hs_i && !eq_target_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dataflow_stream_monitor.sv
// Monitors N_OUT stream handshakes, sequencing IDLE/RUN/DONE against a programmed target.
// Define MULTI_DATAFLOW_MONITOR_TIMEOUT_EN to add the idle-cycle watchdog that forces DONE.
module multi_dataflow_stream_monitor
    import multi_dataflow_package::*;
#(
    parameter int N_OUT     = 2,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int TIMEOUT_W = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       target_i,
    input  logic [N_OUT-1:0]       valid_i,
    input  logic [N_OUT-1:0]       ready_i,
    output logic [N_OUT*CNT_W-1:0] cnt_o,
    output logic                   busy_o,
    output logic                   ready_o,
    output logic                   done_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);

    monitor_state_t   state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic [N_OUT-1:0] hs;
    logic [N_OUT-1:0] eq_vec;
    logic [N_OUT-1:0] ovr_vec;
    logic             all_met;
    logic             load_zero;
    logic             wd_expire;

    assign hs        = valid_i & ready_i;
    assign all_met   = &eq_vec;
    assign load_zero = start_i && !clear_i && (state_q != ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_chan
            multi_dataflow_stream_counter #(
                .CNT_W(CNT_W)
            ) u_counter (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .clear_i    (clear_i),
                .load_zero_i(load_zero),
                .count_en_i (state_q == ST_RUN),
                .watch_en_i (state_q != ST_IDLE),
                .hs_i       (hs[gi]),
                .target_i   (target_q),
                .cnt_o      (cnt_o[gi*CNT_W +: CNT_W]),
                .eq_target_o(eq_vec[gi]),
                .overrun_o  (ovr_vec[gi])
            );
        end
    endgenerate

`ifdef MULTI_DATAFLOW_MONITOR_TIMEOUT_EN
    // Expire on the edge that brings the idle count to all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d      = '0;
        wd_expire = 1'b0;
        if (!clear_i && (state_q == ST_RUN) && !(|hs)) begin
            wd_d      = wd_q + 1'b1;
            wd_expire = (wd_q == WD_LAST);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire = 1'b0;
    wire unused_timeout_w = ^TIMEOUT_W;
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (|ovr_vec);
        timeout_d = timeout_q;
        if (clear_i) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d  = ST_RUN;
                        target_d = target_i;
                    end
                end
                ST_RUN: begin
                    if (all_met) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (wd_expire) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy_o    = (state_q == ST_RUN);
    assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/multi_dataflow_stream_monitor.md
Name: multi_dataflow_stream_monitor

Overview:
Parametrised successor to the single-output engine handshake counter. It observes N_OUT output stream handshakes (valid & ready) from a kernel adapter and keeps one saturating counter per channel. It sequences start, run and done through an FSM, compares each count against a programmed target, and drives done, ready and the per-channel counts to the controller FSM. It sits in the engine, between the kernel adapter streams and the controller flags.

Parameters:
N_OUT, 2, number of monitored output streams (1..16)
CNT_W, 16, width of each per-channel counter and of the target
TIMEOUT_W, 12, width of the watchdog counter (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of counters, flags and FSM
start_i  in  1  one-cycle job start pulse
target_i  in  CNT_W  expected handshakes per channel; sampled on start
valid_i  in  N_OUT  per-channel stream valid
ready_i  in  N_OUT  per-channel stream ready
cnt_o  out  N_OUT*CNT_W  per-channel counts; channel k occupies bits [k*CNT_W +: CNT_W]
busy_o  out  1  high in RUN
ready_o  out  1  high in IDLE and DONE; accepts start
done_o  out  1  one-cycle pulse on entry to DONE
overrun_o  out  1  sticky; a handshake occurred on a channel whose count already equals target
timeout_o  out  1  sticky watchdog flag; tied to 0 when the feature is off

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, all counters and the latched target = 0. Outputs: ready_o=1, busy_o=0, done_o=0, overrun_o=0, timeout_o=0.
- States are IDLE, RUN and DONE.
- IDLE: on start_i, latch target_i, zero all counters, go to RUN.
- RUN: on each cycle where valid_i[k] & ready_i[k], increment counter k by 1.
  - Counter saturates at 2^CNT_W-1; no wrap.
  - When every channel's count equals the target (combinational all_met), go to DONE next edge and pulse done_o for exactly one cycle. Latency is 1 cycle from the final handshake edge.
- Target 0: all_met is true on the first RUN cycle, so DONE is reached 2 edges after start.
- DONE: counts hold. start_i behaves as in IDLE and re-arms the block. Otherwise stay in DONE.
- start_i in RUN: ignored.
- Handshake on channel k while cnt[k]==target (RUN or DONE): counter unchanged, overrun_o set until clear or reset.
- Handshakes in IDLE: not counted.
- clear_i is synchronous and has priority over everything else:
  - FSM=IDLE, counters=0, flags=0.
  - clear_i and start_i in the same cycle: clear wins and start is dropped.
- Async reset mid-RUN aborts the job immediately; no done_o is produced.
- Counter increments are per-channel and independent. Simultaneous handshakes on all channels in one cycle each increment.
- All outputs are registered except ready_o and busy_o, which decode the FSM state register.

Optional Feature:
Macro MULTI_DATAFLOW_MONITOR_TIMEOUT_EN.
- Defined:
  - In RUN, a TIMEOUT_W-bit watchdog counts cycles with no handshake on any channel and resets to 0 on any handshake.
  - When it reaches 2^TIMEOUT_W-1: set timeout_o (sticky), go to DONE, pulse done_o.
  - The counts keep their partial values.
- Undefined: no watchdog logic is instantiated, timeout_o is constant 0, and RUN exits only via all_met, clear or reset.

Decomposition:
- multi_dataflow_package holds:
  - monitor_state_t enum (IDLE, RUN, DONE);
  - ctrl_monitor_t struct (start, clear, target);
  - flags_monitor_t struct (ready, busy, done, overrun, timeout, cnt array);
  - default CNT_W constant.
- Sub-module multi_dataflow_stream_counter: one saturating CNT_W counter with enable, sync clear, load-zero, and eq_target/overrun outputs. Instantiate N_OUT times in a generate loop.

Test Plan:
- N_OUT=2, target=4, 4 handshakes on each channel interleaved -> done_o pulses once, 1 cycle after the last handshake; cnt_o={4,4}; ready_o=1; overrun_o=0.
- target=3, channel0 gets 5 handshakes, channel1 gets 3 -> cnt0=3, overrun_o=1, done_o asserted once.
- target=0, start -> done_o 2 cycles after start; all counts 0.
- clear_i and start_i together in IDLE, then clear_i mid-RUN at count 2 -> FSM stays/returns to IDLE; counts 0; no done_o.
- rst_ni low for 1 cycle mid-RUN at count 7 -> all outputs at reset values immediately; a subsequent start with target=2 completes normally.
- TIMEOUT_EN defined, TIMEOUT_W=4, target=5, stall after 2 handshakes -> after 15 idle cycles timeout_o=1, done_o pulses, cnt=2. Undefined -> remains in RUN indefinitely.
